// File: rtl/fetch_unit.sv
// Instruction fetch stage: walks a combinational ROM from a start address into a
// one-entry instruction register, with decode back-pressure, redirect flush and halt.
module fetch_unit #(
    parameter int         IW        = 16,
    parameter logic [8:0] HALT_WORD = 9'b111111111
) (
    input  logic          CLK,
    input  logic          reset,
    input  logic          start,
    input  logic [IW-1:0] start_addr,
    output logic [IW-1:0] insn_addr,
    input  logic [8:0]    instruction,
    output logic [8:0]    ir,
    output logic [IW-1:0] ir_pc,
    output logic          ir_valid,
    input  logic          ir_ready,
    input  logic          redirect,
    input  logic [IW-1:0] redirect_target,
    output logic          halted,
    output logic [15:0]   fetch_count,
    output logic [1:0]    o_state
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_HALT = 2'd2
    } state_t;

    state_t        r_state;
    logic [IW-1:0] r_pc;
    logic [8:0]    r_ir;
    logic [IW-1:0] r_ir_pc;
    logic          r_ir_valid;
    logic [15:0]   r_fetch_count;

    // Handshake: ir is transferred to decode on any edge where ir_valid && ir_ready.
    // The register may be refilled in that same cycle, so full throughput needs no bubble.
    logic w_capture;
    assign w_capture = (!r_ir_valid || ir_ready) && !redirect;

    always_ff @(posedge CLK) begin
        if (reset) begin
            r_state       <= S_IDLE;
            r_pc          <= '0;
            r_ir          <= '0;
            r_ir_pc       <= '0;
            r_ir_valid    <= 1'b0;
            r_fetch_count <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_pc          <= start_addr;
                        r_fetch_count <= '0;
                        r_ir_valid    <= 1'b0;
                        r_state       <= S_RUN;
                    end
                end
                S_RUN: begin
                    if (redirect) begin
                        r_pc       <= redirect_target;
                        r_ir_valid <= 1'b0;
                    end else if (w_capture) begin
                        r_ir       <= instruction;
                        r_ir_pc    <= r_pc;
                        r_ir_valid <= 1'b1;
                        if (r_fetch_count != 16'hFFFF) begin
                            r_fetch_count <= r_fetch_count + 16'd1;
                        end
                        // The halt word parks the PC on itself so insn_addr shows where fetch stopped.
                        if (instruction == HALT_WORD) begin
                            r_state <= S_HALT;
                        end else begin
                            r_pc <= r_pc + 1'b1;
                        end
                    end
                end
                S_HALT: begin
                    if (start) begin
                        r_pc          <= start_addr;
                        r_fetch_count <= '0;
                        r_ir_valid    <= 1'b0;
                        r_state       <= S_RUN;
                    end else if (ir_ready) begin
                        r_ir_valid <= 1'b0;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign insn_addr   = r_pc;
    assign ir          = r_ir;
    assign ir_pc       = r_ir_pc;
    assign ir_valid    = r_ir_valid;
    assign fetch_count = r_fetch_count;
    assign halted      = (r_state == S_HALT);
    assign o_state     = r_state;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: ROM model, scoreboard of {ir_pc, ir} per consumed word.
module tb_fetch_unit;
    localparam int IW = 16;
    localparam logic [8:0] HALT = 9'h1FF;
    localparam logic [8:0] WA = 9'h011, WB = 9'h022, WC = 9'h033;
    localparam logic [8:0] WX = 9'h0C0, W20 = 9'h0AA, W5 = 9'h055;

    logic          CLK = 1'b0;
    logic          reset = 1'b0, start = 1'b0, ir_ready = 1'b0, redirect = 1'b0;
    logic [IW-1:0] start_addr = '0, redirect_target = '0;
    logic [IW-1:0] insn_addr, ir_pc;
    logic [8:0]    instruction, ir;
    logic          ir_valid, halted;
    logic [15:0]   fetch_count;
    logic [1:0]    o_state;

    logic [8:0]  rom [0:(1<<IW)-1];
    logic [24:0] exp_q[$];
    int n_checks = 0;
    int n_fail = 0;

    assign instruction = rom[insn_addr];

    always #5 CLK = ~CLK;

    fetch_unit #(.IW(IW), .HALT_WORD(HALT)) dut (
        .CLK(CLK), .reset(reset), .start(start), .start_addr(start_addr),
        .insn_addr(insn_addr), .instruction(instruction), .ir(ir), .ir_pc(ir_pc),
        .ir_valid(ir_valid), .ir_ready(ir_ready), .redirect(redirect),
        .redirect_target(redirect_target), .halted(halted),
        .fetch_count(fetch_count), .o_state(o_state)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [IW-1:0] pc, input logic [8:0] w);
        exp_q.push_back({pc, w});
    endtask

    // Consumption is sampled at the negedge; inputs change just after posedge.
    task automatic tick();
        logic [24:0] e;
        @(negedge CLK);
        if (ir_valid && ir_ready) begin
            if (exp_q.size() == 0) begin
                chk("sb_underflow", {7'd0, ir_pc, ir}, 32'hDEAD);
            end else begin
                e = exp_q.pop_front();
                chk("sb_word", {7'd0, ir_pc, ir}, {7'd0, e});
            end
        end
        @(posedge CLK);
        #1;
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_state"}, o_state, 2'd0);
        chk({tag, "_pc"}, insn_addr, 0);
        chk({tag, "_ir"}, ir, 0);
        chk({tag, "_irpc"}, ir_pc, 0);
        chk({tag, "_valid"}, ir_valid, 0);
        chk({tag, "_halted"}, halted, 0);
        chk({tag, "_count"}, fetch_count, 0);
    endtask

    initial begin
        for (int i = 0; i < (1 << IW); i++) rom[i] = 9'(i % 511);
        rom[0] = WA; rom[1] = WB; rom[2] = WC; rom[3] = HALT;
        rom[16'h20] = W20; rom[16'hFFFF] = WX; rom[5] = W5;

        // Reset state
        reset = 1'b1; start = 1'b1; redirect = 1'b1;
        tick();
        chk_reset_vals("rst");
        reset = 1'b0; start = 1'b0;
        // redirect ignored in IDLE
        redirect_target = 16'h0040;
        tick();
        chk("idle_redir_pc", insn_addr, 0);
        chk("idle_state", o_state, 2'd0);
        redirect = 1'b0;

        // Straight-line program to HALT
        ir_ready = 1'b1; start = 1'b1; start_addr = 16'h0000;
        push(0, WA); push(1, WB); push(2, WC); push(3, HALT);
        tick();
        start = 1'b0;
        chk("lat_addr", insn_addr, 0);
        chk("lat_valid0", ir_valid, 0);
        chk("lat_state", o_state, 2'd1);
        tick();
        chk("lat_valid1", ir_valid, 1);
        chk("lat_ir", ir, WA);
        tick(); tick(); tick();
        chk("halt_flag", halted, 1);
        chk("halt_ir", ir, HALT);
        chk("halt_count", fetch_count, 4);
        chk("halt_addr", insn_addr, 3);
        tick();
        chk("halt_clear", ir_valid, 0);
        // redirect ignored in HALT
        redirect = 1'b1; redirect_target = 16'h0020;
        tick();
        redirect = 1'b0;
        chk("halt_redir_addr", insn_addr, 3);
        chk("halt_redir_state", o_state, 2'd2);

        // Restart from HALT with a 3-cycle decode stall after the first capture
        start = 1'b1; start_addr = 16'h0000;
        push(0, WA); push(1, WB); push(2, WC); push(3, HALT);
        tick();
        start = 1'b0; ir_ready = 1'b0;
        chk("restart_count", fetch_count, 0);
        tick();
        for (int i = 0; i < 3; i++) begin
            // start must be ignored while running
            start = (i == 1); start_addr = 16'h0007;
            tick();
            chk("stall_ir", ir, WA);
            chk("stall_irpc", ir_pc, 0);
            chk("stall_pc", insn_addr, 1);
            chk("stall_count", fetch_count, 1);
        end
        start = 1'b0; ir_ready = 1'b1;
        tick(); tick(); tick(); tick();
        chk("stall_final_count", fetch_count, 4);
        chk("stall_sb_empty", exp_q.size(), 0);

        // Redirect while B is valid and accepted
        start = 1'b1; start_addr = 16'h0000;
        push(0, WA); push(1, WB);
        tick();
        start = 1'b0;
        tick(); tick();
        chk("pre_redir_ir", ir, WB);
        redirect = 1'b1; redirect_target = 16'h0020;
        tick();
        redirect = 1'b0;
        chk("redir_valid", ir_valid, 0);
        chk("redir_addr", insn_addr, 16'h0020);
        tick();
        chk("redir_ir", ir, W20);
        chk("redir_irpc", ir_pc, 16'h0020);

        // Reset during a stall with redirect and start asserted
        ir_ready = 1'b0;
        tick();
        chk("stall2_ir", ir, W20);
        reset = 1'b1; redirect = 1'b1; start = 1'b1;
        tick();
        chk_reset_vals("midrst");
        reset = 1'b0; redirect = 1'b0; start = 1'b0;

        // Address wrap at the top of the ROM
        ir_ready = 1'b1; start = 1'b1; start_addr = 16'hFFFF;
        push(16'hFFFF, WX); push(0, WA);
        tick();
        start = 1'b0;
        tick();
        chk("wrap_ir_top", ir, WX);
        chk("wrap_pc", insn_addr, 0);
        tick();
        chk("wrap_ir0", ir, WA);
        chk("wrap_irpc0", ir_pc, 0);
        tick();
        ir_ready = 1'b0;
        chk("wrap_sb_empty", exp_q.size(), 0);

        // Run to HALT, then restart at 5
        reset = 1'b1;
        tick();
        reset = 1'b0; ir_ready = 1'b1; start = 1'b1; start_addr = 16'h0000;
        push(0, WA); push(1, WB); push(2, WC); push(3, HALT);
        tick();
        start = 1'b0;
        tick(); tick(); tick(); tick(); tick();
        chk("h2_halted", halted, 1);
        start = 1'b1; start_addr = 16'h0005;
        push(5, W5);
        tick();
        start = 1'b0;
        chk("h2_count0", fetch_count, 0);
        chk("h2_addr", insn_addr, 5);
        chk("h2_halted_low", halted, 0);
        tick();
        chk("h2_ir", ir, W5);
        chk("h2_irpc", ir_pc, 5);
        chk("h2_count1", fetch_count, 1);
        ir_ready = 1'b0;
        tick();
        ir_ready = 1'b1;
        tick();
        chk("final_sb_empty", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
